tank_pos_rx: RTL and testbench

Receive-side endpoint of the inter-board tank-position link. Deserialises the 8N1 UART line from the opponent board, parses fixed 6-byte position packets, and checks each packet's XOR checksum. Presents the opponent tank's X/Y position as registered 16-bit words to the display pipeline in the 65 MHz pixel-clock domain. Also flags framing errors, checksum errors and link loss.

---
 rtl/tank_link_pkg.sv | 11 +
 rtl/uart_byte_rx.sv | 111 +++++++++++
 rtl/tank_pos_rx.sv | 158 +++++++++++++++
 tb/tb_tank_pos_rx.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tank_link_pkg.sv
// rtl/tank_link_pkg.sv - shared constants and state types for the tank-position link
package tank_link_pkg;

  localparam logic [7:0] HDR_BYTE = 8'hA5;
  localparam int         PKT_LEN  = 6;

  typedef enum logic [2:0] {P_HUNT, P_XH, P_XL, P_YH, P_YL, P_CHK} parse_state_t;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/uart_byte_rx.sv
// rtl/uart_byte_rx.sv - 8N1 UART byte receiver with 16x oversampling
module uart_byte_rx
  import tank_link_pkg::*;
#(
  parameter int DVSR = 35
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int TW = (DVSR > 1) ? $clog2(DVSR) : 1;

  logic          rx_meta_q, rx_sync_q;
  logic [TW-1:0] tick_cnt_q;
  logic          s_tick;

  rx_state_t     state_q, state_d;
  logic [3:0]    s_cnt_q, s_cnt_d;
  logic [2:0]    n_q, n_d;
  logic [7:0]    b_q, b_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;

  assign s_tick = (tick_cnt_q == TW'(DVSR - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      tick_cnt_q <= '0;
      state_q    <= RX_IDLE;
      s_cnt_q    <= '0;
      n_q        <= '0;
      b_q        <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      rx_meta_q  <= rx;
      rx_sync_q  <= rx_meta_q;
      tick_cnt_q <= s_tick ? '0 : tick_cnt_q + 1'b1;
      state_q    <= state_d;
      s_cnt_q    <= s_cnt_d;
      n_q        <= n_d;
      b_q        <= b_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
    end
  end

  // START waits half a bit so every later sample lands mid-bit
  always_comb begin
    state_d = state_q;
    s_cnt_d = s_cnt_q;
    n_d     = n_q;
    b_d     = b_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (!rx_sync_q) begin
          state_d = RX_START;
          s_cnt_d = '0;
        end
      end
      RX_START: begin
        if (s_tick) begin
          if (s_cnt_q == 4'd7) begin
            s_cnt_d = '0;
            n_d     = '0;
            state_d = rx_sync_q ? RX_IDLE : RX_DATA;
          end else begin
            s_cnt_d = s_cnt_q + 4'd1;
          end
        end
      end
      RX_DATA: begin
        if (s_tick) begin
          if (s_cnt_q == 4'd15) begin
            s_cnt_d = '0;
            b_d     = {rx_sync_q, b_q[7:1]};
            if (n_q == 3'd7) state_d = RX_STOP;
            else             n_d = n_q + 3'd1;
          end else begin
            s_cnt_d = s_cnt_q + 4'd1;
          end
        end
      end
      RX_STOP: begin
        if (s_tick) begin
          if (s_cnt_q == 4'd15) begin
            valid_d = rx_sync_q;
            ferr_d  = !rx_sync_q;
            state_d = RX_IDLE;
          end else begin
            s_cnt_d = s_cnt_q + 4'd1;
          end
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign byte_valid = valid_q;
  assign byte_data  = b_q;
  assign frame_err  = ferr_q;

endmodule

// File: rtl/tank_pos_rx.sv
// rtl/tank_pos_rx.sv - opponent tank position receiver: packet parser, timeout and link watchdog
module tank_pos_rx
  import tank_link_pkg::*;
#(
  parameter int CLK_HZ  = 65_000_000,
  parameter int BAUD    = 115200,
  parameter int BYTE_TO = 65_000,
  parameter int LINK_TO = 6_500_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic [15:0] x_pos,
  output logic [15:0] y_pos,
  output logic        pos_valid,
  output logic        chk_err,
  output logic        frame_err,
  output logic        link_ok
);

  localparam int DVSR = CLK_HZ / (16 * BAUD);
  localparam int TOW  = $clog2(BYTE_TO + 1);
  localparam int LW   = $clog2(LINK_TO + 1);

  logic       byte_valid;
  logic [7:0] byte_data;

  uart_byte_rx #(.DVSR(DVSR)) u_byte_rx (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .frame_err (frame_err)
  );

  parse_state_t ps_q, ps_d;
  logic [7:0]   acc_q, acc_d;
  logic [15:0]  x_sh_q, x_sh_d, y_sh_q, y_sh_d;
  logic [TOW-1:0] to_q, to_d;
  logic [15:0]  x_q, x_d, y_q, y_d;
  logic         pv_q, pv_d, ce_q, ce_d;
  logic [LW-1:0] wd_q, wd_d;
  logic         link_q, link_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      ps_q   <= P_HUNT;
      acc_q  <= '0;
      x_sh_q <= '0;
      y_sh_q <= '0;
      to_q   <= '0;
      x_q    <= '0;
      y_q    <= '0;
      pv_q   <= 1'b0;
      ce_q   <= 1'b0;
      wd_q   <= '0;
      link_q <= 1'b0;
    end else begin
      ps_q   <= ps_d;
      acc_q  <= acc_d;
      x_sh_q <= x_sh_d;
      y_sh_q <= y_sh_d;
      to_q   <= to_d;
      x_q    <= x_d;
      y_q    <= y_d;
      pv_q   <= pv_d;
      ce_q   <= ce_d;
      wd_q   <= wd_d;
      link_q <= link_d;
    end
  end

  // A received byte takes priority over the inter-byte timeout
  always_comb begin
    ps_d   = ps_q;
    acc_d  = acc_q;
    x_sh_d = x_sh_q;
    y_sh_d = y_sh_q;
    to_d   = to_q;
    x_d    = x_q;
    y_d    = y_q;
    pv_d   = 1'b0;
    ce_d   = 1'b0;
    if (byte_valid) begin
      to_d = '0;
      case (ps_q)
        P_HUNT: begin
          if (byte_data == HDR_BYTE) begin
            ps_d  = P_XH;
            acc_d = '0;
          end
        end
        P_XH: begin
          x_sh_d[15:8] = byte_data;
          acc_d        = acc_q ^ byte_data;
          ps_d         = P_XL;
        end
        P_XL: begin
          x_sh_d[7:0] = byte_data;
          acc_d       = acc_q ^ byte_data;
          ps_d        = P_YH;
        end
        P_YH: begin
          y_sh_d[15:8] = byte_data;
          acc_d        = acc_q ^ byte_data;
          ps_d         = P_YL;
        end
        P_YL: begin
          y_sh_d[7:0] = byte_data;
          acc_d       = acc_q ^ byte_data;
          ps_d        = P_CHK;
        end
        P_CHK: begin
          if (byte_data == acc_q) begin
            x_d  = x_sh_q;
            y_d  = y_sh_q;
            pv_d = 1'b1;
          end else begin
            ce_d = 1'b1;
          end
          ps_d = P_HUNT;
        end
        default: ps_d = P_HUNT;
      endcase
    end else if (frame_err) begin
      ps_d = P_HUNT;
      to_d = '0;
    end else if (ps_q == P_HUNT) begin
      to_d = '0;
    end else if (to_q == TOW'(BYTE_TO)) begin
      ps_d = P_HUNT;
      to_d = '0;
    end else begin
      to_d = to_q + 1'b1;
    end
  end

  // Watchdog saturates so link_ok stays low until the next good packet
  always_comb begin
    wd_d   = wd_q;
    link_d = link_q;
    if (pv_d) begin
      wd_d   = '0;
      link_d = 1'b1;
    end else begin
      if (wd_q != LW'(LINK_TO)) wd_d = wd_q + 1'b1;
      if (wd_d == LW'(LINK_TO)) link_d = 1'b0;
    end
  end

  assign x_pos     = x_q;
  assign y_pos     = y_q;
  assign pos_valid = pv_q;
  assign chk_err   = ce_q;
  assign link_ok   = link_q;

endmodule

// File: tb/tb_tank_pos_rx.sv
// tb/tb_tank_pos_rx.sv - self-checking bench for tank_pos_rx with a packet-level reference model
module tb_tank_pos_rx;
  import tank_link_pkg::*;

  localparam int CLK_HZ  = 3_686_400;
  localparam int BAUD    = 115200;
  localparam int BYTE_TO = 1000;
  localparam int LINK_TO = 6000;
  localparam int BIT_CYC = 16 * (CLK_HZ / (16 * BAUD));
  localparam int TO_GAP  = 1200;

  localparam int EV_POS = 0;
  localparam int EV_CHK = 1;
  localparam int EV_FRM = 2;

  typedef struct {
    int          kind;
    logic [15:0] x;
    logic [15:0] y;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx  = 1'b1;
  logic [15:0] x_pos, y_pos;
  logic        pos_valid, chk_err, frame_err, link_ok;

  ev_t        evq[$];
  logic [7:0] pkt_buf[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         n_pv = 0, n_ce = 0, n_fe = 0;
  logic       rst_s = 1'b1;
  logic [15:0] cur_x = '0, cur_y = '0;
  bit         seen = 1'b0;
  int         since = 0;

  tank_pos_rx #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD),
    .BYTE_TO(BYTE_TO),
    .LINK_TO(LINK_TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .x_pos    (x_pos),
    .y_pos    (y_pos),
    .pos_valid(pos_valid),
    .chk_err  (chk_err),
    .frame_err(frame_err),
    .link_ok  (link_ok)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rst_s <= rst;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_pulse(input int kind, input string name);
    ev_t e;
    check({name, "_expected"}, (evq.size() != 0), 1);
    if (evq.size() != 0) begin
      e = evq.pop_front();
      check({name, "_kind"}, kind, e.kind);
      if (kind == EV_POS && e.kind == EV_POS) begin
        check("pos_x", x_pos, e.x);
        check("pos_y", y_pos, e.y);
        cur_x = e.x;
        cur_y = e.y;
      end
    end
  endtask

  // Packet-level model: what a correct receiver must report for each byte
  task automatic model_byte(input logic [7:0] b, input bit good);
    ev_t e;
    logic [7:0] c;
    e.x = '0;
    e.y = '0;
    if (!good) begin
      e.kind = EV_FRM;
      evq.push_back(e);
      pkt_buf.delete();
      return;
    end
    if (pkt_buf.size() == 0 && b != HDR_BYTE) return;
    pkt_buf.push_back(b);
    if (pkt_buf.size() == PKT_LEN) begin
      c      = pkt_buf[1] ^ pkt_buf[2] ^ pkt_buf[3] ^ pkt_buf[4];
      e.x    = {pkt_buf[1], pkt_buf[2]};
      e.y    = {pkt_buf[3], pkt_buf[4]};
      e.kind = (c == pkt_buf[5]) ? EV_POS : EV_CHK;
      evq.push_back(e);
      pkt_buf.delete();
    end
  endtask

  always @(negedge clk) begin
    if (rst_s) begin
      evq.delete();
      cur_x = '0;
      cur_y = '0;
      seen  = 1'b0;
      since = 0;
      check("rst_x_pos", x_pos, 0);
      check("rst_y_pos", y_pos, 0);
      check("rst_pulses", {pos_valid, chk_err, frame_err}, 0);
      check("rst_link_ok", link_ok, 0);
    end else begin
      if (pos_valid) begin expect_pulse(EV_POS, "pos_valid"); n_pv++; end
      if (chk_err)   begin expect_pulse(EV_CHK, "chk_err");   n_ce++; end
      if (frame_err) begin expect_pulse(EV_FRM, "frame_err"); n_fe++; end
      if (pos_valid) begin
        since = 0;
        seen  = 1'b1;
      end else if (since <= LINK_TO) begin
        since++;
      end
      if (since != LINK_TO) check("link_ok", link_ok, (seen && since < LINK_TO));
      check("x_pos", x_pos, cur_x);
      check("y_pos", y_pos, cur_y);
    end
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit good, input int gap);
    model_byte(b, good);
    rx = 1'b0;
    wait_n(BIT_CYC);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_n(BIT_CYC);
    end
    if (good) begin
      rx = 1'b1;
      wait_n(BIT_CYC);
    end else begin
      // low long enough to cover the stop sample, then idle so the line settles
      rx = 1'b0;
      wait_n(24);
      rx = 1'b1;
      wait_n(40);
    end
    wait_n(gap);
    if (gap > BYTE_TO) pkt_buf.delete();
  endtask

  task automatic send_pkt(input logic [47:0] p);
    for (int i = 5; i >= 0; i--) send_byte(p[i*8 +: 8], 1'b1, 0);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (evq.size() != 0 && k < 400) begin
      wait_n(1);
      k++;
    end
    check("drain", evq.size(), 0);
    wait_n(4);
  endtask

  function automatic int rgap();
    return ($urandom_range(0, 9) == 0) ? TO_GAP : int'($urandom_range(0, 40));
  endfunction

  initial begin
    int pv0, ce0, fe0;
    logic [15:0] rxv, ryv;
    logic [7:0]  c;
    logic [7:0]  pb[6];

    wait_n(5);
    rst = 1'b0;
    wait_n(20);

    // checksum 01^23^02^34 = 14
    pv0 = n_pv; ce0 = n_ce;
    send_pkt(48'hA5_01_23_02_34_14);
    drain();
    check("t1_x", x_pos, 16'h0123);
    check("t1_y", y_pos, 16'h0234);
    check("t1_link", link_ok, 1);
    check("t1_npv", n_pv - pv0, 1);
    check("t1_nce", n_ce - ce0, 0);

    pv0 = n_pv; ce0 = n_ce;
    send_pkt(48'hA5_01_23_02_34_16);
    drain();
    check("t2_x", x_pos, 16'h0123);
    check("t2_nce", n_ce - ce0, 1);
    check("t2_npv", n_pv - pv0, 0);

    fe0 = n_fe;
    send_byte(8'hA5, 1'b1, 0);
    send_byte(8'h01, 1'b1, 0);
    send_byte(8'h23, 1'b0, 0);
    send_pkt(48'hA5_00_10_00_20_30);
    drain();
    check("t3_nfe", n_fe - fe0, 1);
    check("t3_x", x_pos, 16'h0010);
    check("t3_y", y_pos, 16'h0020);

    pv0 = n_pv + n_ce + n_fe;
    rx = 1'b0;
    wait_n(6);
    rx = 1'b1;
    wait_n(400);
    check("t4_glitch", n_pv + n_ce + n_fe, pv0);

    send_byte(8'h55, 1'b1, 0);
    send_pkt(48'hA5_00_01_00_02_03);
    drain();
    check("t5_x", x_pos, 16'h0001);
    check("t5_y", y_pos, 16'h0002);

    ce0 = n_ce;
    send_byte(8'hA5, 1'b1, 0);
    send_byte(8'h00, 1'b1, TO_GAP);
    send_pkt(48'hA5_00_05_00_06_03);
    drain();
    check("t6_x", x_pos, 16'h0005);
    check("t6_y", y_pos, 16'h0006);
    check("t6_nce", n_ce - ce0, 0);

    wait_n(LINK_TO + 20);
    check("t7_link_lost", link_ok, 0);

    for (int it = 0; it < 10; it++) begin
      rxv = 16'($urandom);
      ryv = 16'($urandom);
      c   = rxv[15:8] ^ rxv[7:0] ^ ryv[15:8] ^ ryv[7:0];
      if ($urandom_range(0, 3) == 0) c = c ^ (8'd1 << $urandom_range(0, 7));
      pb[0] = HDR_BYTE; pb[1] = rxv[15:8]; pb[2] = rxv[7:0];
      pb[3] = ryv[15:8]; pb[4] = ryv[7:0]; pb[5] = c;
      if ($urandom_range(0, 3) == 0) send_byte(8'($urandom), 1'b1, rgap());
      for (int i = 0; i < 6; i++) send_byte(pb[i], ($urandom_range(0, 14) != 0), rgap());
      drain();
    end

    send_pkt(48'hA5_11_22_33_44_44);
    drain();
    check("t8_pre_x", x_pos, 16'h1122);
    send_byte(8'hA5, 1'b1, 0);
    send_byte(8'h01, 1'b1, 0);
    rx = 1'b0;
    wait_n(50);
    rst = 1'b1;
    pkt_buf.delete();
    wait_n(3);
    rx = 1'b1;
    wait_n(5);
    rst = 1'b0;
    wait_n(1);
    check("t8_rst_x", x_pos, 0);
    check("t8_rst_y", y_pos, 0);
    check("t8_rst_link", link_ok, 0);
    wait_n(50);
    send_pkt(48'hA5_12_34_56_78_08);
    drain();
    check("t8_x", x_pos, 16'h1234);
    check("t8_y", y_pos, 16'h5678);
    check("t8_link", link_ok, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    wait_n(120000);
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
